// File: rtl/fir_lut_compensator.sv
// Post-FIR error compensator: offset-binary segment lookup, step or linear-interpolated
// correction from a runtime-loadable table, saturated to the unsigned output range.
module fir_lut_compensator #(
    parameter int DATA_W    = 12,
    parameter int SEG_SHIFT = 6,
    parameter int CORR_W    = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic [1:0]                  cfg_mode,
    input  logic                        tbl_we,
    input  logic [DATA_W-SEG_SHIFT-1:0] tbl_addr,
    input  logic [CORR_W-1:0]           tbl_wdata,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_clip
);

    localparam int IDX_W  = DATA_W - SEG_SHIFT;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int CW2    = CORR_W + 2;
    localparam int PROD_W = CORR_W + SEG_SHIFT + 2;
    localparam int SUM_W  = ((CORR_W > DATA_W) ? CORR_W : DATA_W) + 2;
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << DATA_W) - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         init_cnt;
    logic signed [CORR_W-1:0] tbl [DEPTH];

    logic                     s1_valid;
    logic [DATA_W-1:0]        s1_u;
    logic [1:0]               s1_mode;
    logic [IDX_W-1:0]         s1_idx;
    logic [IDX_W-1:0]         s1_idx_next;

    logic                     s2_valid;
    logic [DATA_W-1:0]        s2_u;
    logic [1:0]               s2_mode;
    logic [SEG_SHIFT-1:0]     s2_frac;
    logic signed [CORR_W-1:0] s2_c0;
    logic signed [CORR_W-1:0] s2_c1;

    logic signed [CORR_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [CW2-1:0]    interp;

    logic                     s3_valid;
    logic [DATA_W-1:0]        s3_u;
    logic signed [CW2-1:0]    s3_corr;

    logic signed [SUM_W-1:0]  sum;
    logic                     clip_lo;
    logic                     clip_hi;

    // After reset the table is cleared one entry per cycle before samples are accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            in_ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                    end
                end
                default: in_ready <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            tbl[init_cnt] <= '0;
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_u     <= '0;
            s1_mode  <= '0;
        end else begin
            s1_valid <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                s1_u    <= {~in_data[DATA_W-1], in_data[DATA_W-2:0]};
                s1_mode <= cfg_mode;
            end
        end
    end

    // The top segment has no right neighbour, so it interpolates against itself.
    always_comb begin
        s1_idx      = s1_u[DATA_W-1:SEG_SHIFT];
        s1_idx_next = (s1_idx == '1) ? s1_idx : s1_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_u     <= '0;
            s2_mode  <= '0;
            s2_frac  <= '0;
            s2_c0    <= '0;
            s2_c1    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_u    <= s1_u;
                s2_mode <= s1_mode;
                s2_frac <= s1_u[SEG_SHIFT-1:0];
                s2_c0   <= tbl[s1_idx];
                s2_c1   <= tbl[s1_idx_next];
            end
        end
    end

    always_comb begin
        diff   = {s2_c1[CORR_W-1], s2_c1} - {s2_c0[CORR_W-1], s2_c0};
        prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, s2_frac}));
        interp = CW2'(s2_c0) + CW2'(prod >>> SEG_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_u     <= '0;
            s3_corr  <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_u <= s2_u;
                case (s2_mode)
                    2'd1:    s3_corr <= CW2'(s2_c0);
                    2'd2:    s3_corr <= interp;
                    default: s3_corr <= '0;
                endcase
            end
        end
    end

    always_comb begin
        sum     = SUM_W'($signed({1'b0, s3_u})) + SUM_W'(s3_corr);
        clip_lo = sum[SUM_W-1];
        clip_hi = !clip_lo && (sum > OUT_MAX);
    end

    // Output data and clip flag hold between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_clip  <= 1'b0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                if (clip_lo) begin
                    out_data <= '0;
                    out_clip <= 1'b1;
                end else if (clip_hi) begin
                    out_data <= '1;
                    out_clip <= 1'b1;
                end else begin
                    out_data <= sum[DATA_W-1:0];
                    out_clip <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_lut_compensator.sv
// Self-checking bench for fir_lut_compensator: directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model of the compensation rules.
module tb_fir_lut_compensator;

    localparam int DATA_W    = 12;
    localparam int SEG_SHIFT = 6;
    localparam int CORR_W    = 12;
    localparam int DEPTH     = 64;
    localparam int SEG_SIZE  = 64;
    localparam int MAXV      = 4095;
    localparam int OFFSET    = 2048;

    typedef struct {
        bit valid;
        int data;
        bit clip;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic                        in_ready;
    logic [1:0]                  cfg_mode;
    logic                        tbl_we;
    logic [DATA_W-SEG_SHIFT-1:0] tbl_addr;
    logic [CORR_W-1:0]           tbl_wdata;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic                        out_clip;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   mtbl [DEPTH];
    exp_t pipe_q [$];
    int   init_edges;
    bit   model_ready;
    int   held_data;
    bit   held_clip;

    fir_lut_compensator #(
        .DATA_W    (DATA_W),
        .SEG_SHIFT (SEG_SHIFT),
        .CORR_W    (CORR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cfg_mode  (cfg_mode),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_clip  (out_clip)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int floor_div(int p, int d);
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    // Reference: offset-binary sample, segment lookup, correction, then clamp to [0, MAXV].
    function automatic exp_t predict(int din, int mode);
        exp_t r;
        int u, idx, frac, c0, c1, corr, s;
        u    = din + OFFSET;
        idx  = u / SEG_SIZE;
        frac = u % SEG_SIZE;
        c0   = mtbl[idx];
        c1   = mtbl[(idx == DEPTH - 1) ? idx : idx + 1];
        case (mode)
            1:       corr = c0;
            2:       corr = c0 + floor_div((c1 - c0) * frac, SEG_SIZE);
            default: corr = 0;
        endcase
        s = u + corr;
        r.valid = 1'b1;
        if (s < 0) begin
            r.data = 0;
            r.clip = 1'b1;
        end else if (s > MAXV) begin
            r.data = MAXV;
            r.clip = 1'b1;
        end else begin
            r.data = s;
            r.clip = 1'b0;
        end
        return r;
    endfunction

    task automatic model_clear();
        foreach (mtbl[i]) mtbl[i] = 0;
        pipe_q.delete();
        for (int i = 0; i < 3; i++) pipe_q.push_back('{valid: 1'b0, data: 0, clip: 1'b0});
        init_edges  = 0;
        model_ready = 1'b0;
        held_data   = 0;
        held_clip   = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        exp_t it;
        exp_t out_exp;
        @(posedge clk);
        it = '{valid: 1'b0, data: 0, clip: 1'b0};
        if (model_ready && tbl_we) mtbl[tbl_addr] = int'($signed(tbl_wdata));
        if (model_ready && in_valid) it = predict(int'($signed(in_data)), int'(cfg_mode));
        if (!model_ready) begin
            init_edges++;
            if (init_edges == DEPTH) model_ready = 1'b1;
        end
        pipe_q.push_back(it);
        #1;
        out_exp = pipe_q.pop_front();
        if (out_exp.valid) begin
            held_data = out_exp.data;
            held_clip = out_exp.clip;
        end
        checkOutput("in_ready", 32'(in_ready), 32'(model_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(out_exp.valid));
        checkOutput("out_data", 32'(out_data), 32'(held_data));
        checkOutput("out_clip", 32'(out_clip), 32'(held_clip));
    endtask

    task automatic applyStimulus(bit v, int d, int m, bit we, int a, int w);
        in_valid  = v;
        in_data   = d[DATA_W-1:0];
        cfg_mode  = m[1:0];
        tbl_we    = we;
        tbl_addr  = a[DATA_W-SEG_SHIFT-1:0];
        tbl_wdata = w[CORR_W-1:0];
        tick();
        in_valid  = 1'b0;
        tbl_we    = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_clip", 32'(out_clip), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, we;
        int d, m, a, w;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_mode  = 2'd0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;

        // Init sequence: in_ready checked low on each of the 64 init edges.
        apply_reset();
        idle(DEPTH);
        applyStimulus(1, 100, 2, 0, 0, 0);
        idle(4);

        // Bypass at both input extremes, back to back.
        applyStimulus(1, -2048, 0, 0, 0, 0);
        applyStimulus(1, 2047, 0, 0, 0, 0);
        idle(4);

        // Step mode within one segment.
        applyStimulus(0, 0, 1, 1, 32, -100);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 63, 1, 0, 0, 0);
        idle(4);

        // Interpolation mid-segment and clamped top segment with saturation.
        applyStimulus(0, 0, 2, 1, 10, 0);
        applyStimulus(0, 0, 2, 1, 11, 64);
        applyStimulus(1, -1376, 2, 0, 0, 0);
        applyStimulus(0, 0, 2, 1, 63, 50);
        applyStimulus(1, 2000, 2, 0, 0, 0);
        idle(4);

        // Low-side saturation, then a mode change behind an in-flight sample.
        applyStimulus(0, 0, 1, 1, 0, -300);
        applyStimulus(1, -2048, 1, 0, 0, 0);
        applyStimulus(1, -2048, 0, 0, 0, 0);
        idle(4);

        // Write colliding with an S2 read of the same entry.
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 32, 7);
        applyStimulus(1, 0, 1, 0, 0, 0);
        idle(4);

        // Randomized traffic, concentrated on a few segments so writes hit live entries.
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                d = int'($urandom_range(1920, 2175)) - OFFSET;
            else
                d = int'($urandom_range(0, 4095)) - OFFSET;
            m  = int'($urandom_range(0, 3));
            we = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(30, 33));
            w  = int'($urandom_range(0, 4095)) - OFFSET;
            applyStimulus(v, d, m, we, a, w);
        end
        idle(4);

        // Reset mid-stream with samples in flight and out_valid high.
        for (int i = 0; i < 5; i++) applyStimulus(1, 500 + i, 1, 0, 0, 0);
        checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
        apply_reset();
        applyStimulus(0, 0, 0, 1, 0, 500);
        idle(DEPTH - 1);
        applyStimulus(1, -2048, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_lut_compensator.md
Name: fir_lut_compensator

Overview:
Parametrised, pipelined post-FIR error compensator with a runtime-loadable table.
- Converts the signed FIR output to offset-binary and uses the top bits as a segment index; segments are a power of two wide, so no divider is needed.
- Adds a signed correction from a table, either stepwise or linearly interpolated, then saturates to the unsigned output range.
- Sits between the FIR filter output and the downstream unsigned sample consumers; the table is written by the host configuration logic.

Parameters:
DATA_W, 12, sample width for signed input and unsigned output.
SEG_SHIFT, 6, log2 of segment width in codes; table depth is 2^(DATA_W-SEG_SHIFT), 64 by default.
CORR_W, 12, signed width of each table entry.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input sample strobe.
in_data  in  DATA_W  signed FIR output.
in_ready  out  1  high once table init is complete; samples with in_valid while in_ready=0 are dropped.
cfg_mode  in  2  0=bypass, 1=step, 2=interpolate, 3=bypass.
tbl_we  in  1  table write strobe.
tbl_addr  in  DATA_W-SEG_SHIFT  table write address.
tbl_wdata  in  CORR_W  signed correction value.
out_valid  out  1  output strobe.
out_data  out  DATA_W  compensated unsigned sample.
out_clip  out  1  high with out_valid when saturation occurred.

Behaviour:
Reset values:
- Reset is asynchronous, active-low on rst_n; the design is clocked on clk.
- All outputs reset to 0: in_ready, out_valid, out_data, out_clip.
- All pipeline valid bits are cleared; the FSM enters INIT with the address counter at 0.

FSM:
- INIT: writes 0 to table[cnt], incrementing cnt each cycle. On the last address, go to RUN. Init takes 2^(DATA_W-SEG_SHIFT) cycles.
- RUN: in_ready=1. Remains in RUN until reset.
- tbl_we is ignored in INIT. In RUN, a write lands at the clock edge.

Pipeline (4-cycle latency, fully pipelined, one sample per cycle):
- S1: u = in_data + 2^(DATA_W-1), unsigned DATA_W (MSB invert). Capture mode with the sample; mode travels with the sample.
  - idx = u[DATA_W-1:SEG_SHIFT].
  - frac = u[SEG_SHIFT-1:0].
- S2: register c0 = table[idx] and c1 = table[min(idx+1, last)]. The last segment clamps, so it is effectively stepwise.
- S3: compute corr.
  - Mode 1: corr = c0.
  - Mode 2: corr = c0 + floor(((c1-c0)*frac) / 2^SEG_SHIFT). The difference is CORR_W+1 bits signed; frac is treated as unsigned zero-extended; the shift is arithmetic.
  - Mode 0/3: corr = 0.
- S4: s = u + corr in DATA_W+2 signed.
  - s<0 gives out_data=0, out_clip=1.
  - s>2^DATA_W-1 gives out_data=all ones, out_clip=1.
  - Otherwise out_data=s, out_clip=0.
  - out_valid asserts with the S4 result.

Holding rules:
- out_data and out_clip hold their last value when out_valid=0.
- out_clip is 0 whenever bypass mode is selected.

Table/read collision:
- A write to the address read in S2 on the same cycle returns the old value.
- The write is visible to S2 reads from the next cycle.

Configuration changes:
- A cfg_mode change affects only samples entering S1 after the change. In-flight samples keep their captured mode.

Reset mid-stream:
- All in-flight samples are discarded and out_valid drops immediately (asynchronous).
- The table is re-cleared via INIT. Host writes must be reissued.

No backpressure on the output: the consumer must accept every out_valid.

Test Plan:
1. Reset release, DATA_W=12/SEG_SHIFT=6 -> in_ready low for exactly 64 cycles then high; in_data=100 with mode 2 -> out_data=2148 four cycles later, out_clip=0.
2. Mode 0, in_data=-2048 then 2047 -> out_data=0 then 4095 at latency 4, out_clip=0, back-to-back valids preserved.
3. Mode 1, write table[32]=-100, in_data=0 -> out_data=1948; in_data=63 (u=2111, same segment) -> out_data=2011.
4. Mode 2, table[10]=0, table[11]=64, in_data=-1376 (u=672, frac=32) -> corr 32, out_data=704; table[63]=50, in_data=2000 -> last segment clamps, out_data=4098 saturates to 4095, out_clip=1.
5. table[0]=-300, mode 1, in_data=-2048 -> out_data=0, out_clip=1; a sample in flight when cfg_mode switches to 0 still receives the correction.
6. Assert rst_n low with 3 samples in flight -> out_valid=0 immediately, no stale outputs after release, table reads 0 again, in_ready low for 64 cycles; a tbl_we during INIT has no effect.
